// File: rtl/tanh_pkg.sv
// Shared definitions for the piecewise-linear tanh unit: segment encoding
// and breakpoint/offset constants as functions of the lane width.
package tanh_pkg;

  typedef enum logic [1:0] {
    SEG_LIN  = 2'd0,
    SEG_HALF = 2'd1,
    SEG_QTR  = 2'd2,
    SEG_SAT  = 2'd3
  } seg_e;

  // Breakpoints on the unsigned input code (x in [0,4) with W-2 fraction bits)
  function automatic int unsigned seg_t1(input int unsigned w);
    return 32'd1 << (w - 3);
  endfunction

  function automatic int unsigned seg_t2(input int unsigned w);
    return 32'd1 << (w - 2);
  endfunction

  function automatic int unsigned seg_t3(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // Additive offsets of the half-slope and quarter-slope segments
  function automatic int unsigned seg_off_half(input int unsigned w);
    return 32'd1 << (w - 2);
  endfunction

  function automatic int unsigned seg_off_qtr(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/tanh_pwl_lane.sv
// One tanh lane: segment selection on the incoming code (feeds stage 1)
// and shift-add evaluation of the stage-1 contents (feeds stage 2).
module tanh_pwl_lane
  import tanh_pkg::*;
#(
  parameter int unsigned W           = 4,
  parameter int unsigned APPROX_LSBS = 2
) (
  input  logic [W-1:0] x_in,
  output seg_e         seg_o,
  input  logic [W-1:0] x,
  input  seg_e         seg,
  input  logic         mode,
  output logic [W-1:0] y,
  output logic         sat
);

  localparam logic [W-1:0] T1       = W'(seg_t1(W));
  localparam logic [W-1:0] T2       = W'(seg_t2(W));
  localparam logic [W-1:0] T3       = W'(seg_t3(W));
  localparam logic [W+1:0] OFF_HALF = (W+2)'(seg_off_half(W));
  localparam logic [W+1:0] OFF_QTR  = (W+2)'(seg_off_qtr(W));
  localparam logic [W-1:0] KEEP     = ~(W'((32'd1 << APPROX_LSBS) - 32'd1));

  logic [W+1:0] r;

  // Classify the incoming code into its PWL segment
  always_comb begin
    seg_o = SEG_LIN;
    if (x_in >= T3)      seg_o = SEG_SAT;
    else if (x_in >= T2) seg_o = SEG_QTR;
    else if (x_in >= T1) seg_o = SEG_HALF;
  end

  // Evaluate the segment at W+2 bits, clamp, then truncate in approximate mode
  always_comb begin
    r = '0;
    case (seg)
      SEG_LIN:  r = {x, 2'b00};
      SEG_HALF: r = {1'b0, x, 1'b0} + OFF_HALF;
      SEG_QTR:  r = {2'b00, x} + OFF_QTR;
      default:  r = '0;
    endcase
    sat = (seg == SEG_SAT) || (r[W+1:W] != 2'b00);
    y   = sat ? '1 : r[W-1:0];
    if (mode) y = y & KEEP;
  end

endmodule

// File: rtl/tanh_pwl_pipe.sv
// Multi-lane 2-stage valid/ready tanh PWL unit with saturation counter.
module tanh_pwl_pipe
  import tanh_pkg::*;
#(
  parameter int unsigned W           = 4,
  parameter int unsigned LANES       = 1,
  parameter int unsigned APPROX_LSBS = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic               out_mode,
  input  logic               sat_clr,
  output logic [CNT_W-1:0]   sat_count
);

  logic               s1_full;
  logic [LANES*W-1:0] s1_data;
  logic               s1_mode;
  seg_e               s1_seg  [LANES];
  seg_e               seg_nxt [LANES];
  logic [LANES*W-1:0] res_nxt;
  logic [LANES-1:0]   sat_nxt;
  logic [LANES-1:0]   s2_sat;
  logic               s2_ready;
  logic               s2_load;
  logic               in_fire;
  logic               out_fire;
  logic [CNT_W:0]     pop;
  logic [CNT_W:0]     sum;

  // Each lane instance spans both stages: seg-select before S1, evaluate before S2
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    tanh_pwl_lane #(
      .W          (W),
      .APPROX_LSBS(APPROX_LSBS)
    ) u_lane (
      .x_in (in_data[k*W +: W]),
      .seg_o(seg_nxt[k]),
      .x    (s1_data[k*W +: W]),
      .seg  (s1_seg[k]),
      .mode (s1_mode),
      .y    (res_nxt[k*W +: W]),
      .sat  (sat_nxt[k])
    );
  end

  assign s2_ready = !out_valid || out_ready;
  assign s2_load  = s1_full && s2_ready;
  assign in_ready = !s1_full || s2_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Stage 1: capture lane codes, mode and segment indices
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_full <= 1'b0;
      s1_data <= '0;
      s1_mode <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) s1_seg[i] <= SEG_LIN;
    end else if (in_fire) begin
      s1_full <= 1'b1;
      s1_data <= in_data;
      s1_mode <= in_mode;
      for (int unsigned i = 0; i < LANES; i++) s1_seg[i] <= seg_nxt[i];
    end else if (s2_load) begin
      s1_full <= 1'b0;
    end
  end

  // Stage 2: capture results; frozen while the output is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 1'b0;
      s2_sat    <= '0;
    end else if (s2_ready) begin
      out_valid <= s1_full;
      if (s1_full) begin
        out_data <= res_nxt;
        out_mode <= s1_mode;
        s2_sat   <= sat_nxt;
      end
    end
  end

  // Saturated-lane popcount of the beat on the output and the widened running sum
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < LANES; i++) pop = pop + (CNT_W+1)'(s2_sat[i]);
    sum = {1'b0, sat_count} + pop;
  end

  // Saturating event counter; clear wins over that cycle's increment
  always_ff @(posedge clk) begin
    if (reset || sat_clr) begin
      sat_count <= '0;
    end else if (out_fire) begin
      if (sum > {1'b0, {CNT_W{1'b1}}}) sat_count <= '1;
      else                             sat_count <= sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_tanh_pwl_pipe.sv
// Directed self-checking bench for tanh_pwl_pipe (single-lane and 4-lane builds).
module tb_tanh_pwl_pipe;

  logic        clk = 1'b0;
  logic        reset;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          exp_cnt1 = 0;

  // Single-lane build
  logic        in_valid1, in_ready1, in_mode1, out_valid1, out_ready1, out_mode1, sat_clr1;
  logic [3:0]  in_data1, out_data1;
  logic [15:0] sat_count1;

  // Four-lane build with a narrow counter so its ceiling is reachable
  logic        in_valid4, in_ready4, in_mode4, out_valid4, out_ready4, out_mode4, sat_clr4;
  logic [15:0] in_data4, out_data4;
  logic [2:0]  sat_count4;

  tanh_pwl_pipe #(.W(4), .LANES(1), .APPROX_LSBS(2), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_mode(in_mode1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_mode(out_mode1),
    .sat_clr(sat_clr1), .sat_count(sat_count1)
  );

  tanh_pwl_pipe #(.W(4), .LANES(4), .APPROX_LSBS(2), .CNT_W(3)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_mode(in_mode4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_mode(out_mode4),
    .sat_clr(sat_clr4), .sat_count(sat_count4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid1); end
    checks++; if (out_data1 !== 4'd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data1); end
    checks++; if (out_mode1 !== 1'b0) begin errors++; $display("FAIL reset_out_mode: got %b expected 0", out_mode1); end
    checks++; if (sat_count1 !== 16'd0) begin errors++; $display("FAIL reset_sat_count: got %0d expected 0", sat_count1); end
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready1); end
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid4: got %b expected 0", out_valid4); end
  endtask

  // One isolated beat through the single-lane unit with out_ready held high
  task automatic beat1(input logic [3:0] d, input logic m, input logic [3:0] exp, input bit exp_sat, input string name);
    bit got = 0;
    in_valid1 = 1'b1; in_data1 = d; in_mode1 = m; out_ready1 = 1'b1;
    for (int n = 0; n < 10 && !in_ready1; n++) step();
    step();
    in_valid1 = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid1) begin got = 1; break; end
      step();
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s_timeout: got no out_valid expected out_valid within 10 cycles", name);
    end else begin
      if (out_data1 !== exp) begin errors++; $display("FAIL %s_data: got %0d expected %0d", name, out_data1, exp); end
      checks++;
      if (out_mode1 !== m) begin errors++; $display("FAIL %s_mode: got %b expected %b", name, out_mode1, m); end
    end
    if (exp_sat) exp_cnt1++;
    step();
    checks++;
    if (sat_count1 !== 16'(exp_cnt1)) begin errors++; $display("FAIL %s_sat_count: got %0d expected %0d", name, sat_count1, exp_cnt1); end
  endtask

  task automatic test_exact();
    beat1(4'd0,  1'b0, 4'd0,  0, "exact_0");
    beat1(4'd1,  1'b0, 4'd4,  0, "exact_1");
    beat1(4'd2,  1'b0, 4'd8,  0, "exact_2");
    beat1(4'd3,  1'b0, 4'd10, 0, "exact_3");
    beat1(4'd4,  1'b0, 4'd12, 0, "exact_4");
    beat1(4'd7,  1'b0, 4'd15, 0, "exact_7");
    beat1(4'd8,  1'b0, 4'd15, 1, "exact_8");
    beat1(4'd15, 1'b0, 4'd15, 1, "exact_15");
  endtask

  task automatic test_approx();
    beat1(4'd3,  1'b1, 4'd8,  0, "approx_3");
    beat1(4'd4,  1'b1, 4'd12, 0, "approx_4");
    beat1(4'd15, 1'b1, 4'd12, 1, "approx_15");
  endtask

  task automatic test_back_to_back();
    logic [3:0] bb_exp [10];
    int nin = 0, nout = 0, first_acc = -1, first_out = -1, last_out = -1, gaps = 0;
    bb_exp = '{4'd0, 4'd4, 4'd8, 4'd10, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15, 4'd15};
    out_ready1 = 1'b1;
    for (int c = 0; c < 40 && nout < 10; c++) begin
      in_valid1 = (nin < 10); in_data1 = 4'(nin); in_mode1 = 1'b0;
      #1;
      if (out_valid1) begin
        if (first_out < 0) first_out = cyc;
        if (last_out >= 0 && cyc != last_out + 1) gaps++;
        last_out = cyc;
        checks++;
        if (out_data1 !== bb_exp[nout]) begin errors++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", nout, out_data1, bb_exp[nout]); end
        nout++;
      end
      if (in_valid1 && in_ready1) begin
        if (first_acc < 0) first_acc = cyc;
        nin++;
      end
      step();
    end
    in_valid1 = 1'b0;
    exp_cnt1 += 2;
    checks++; if (nout != 10) begin errors++; $display("FAIL b2b_count: got %0d expected 10", nout); end
    checks++; if (first_out != first_acc + 2) begin errors++; $display("FAIL b2b_latency: got %0d expected 2", first_out - first_acc); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_gaps: got %0d expected 0", gaps); end
    checks++; if (sat_count1 !== 16'(exp_cnt1)) begin errors++; $display("FAIL b2b_sat_count: got %0d expected %0d", sat_count1, exp_cnt1); end
  endtask

  task automatic test_stall();
    logic [3:0] st_exp [8];
    logic [3:0] held = '0;
    bit have_held = 0;
    int nin = 0, nout = 0;
    st_exp = '{4'd0, 4'd4, 4'd8, 4'd10, 4'd12, 4'd13, 4'd14, 4'd15};
    for (int c = 0; c < 40 && nout < 8; c++) begin
      in_valid1 = (nin < 8); in_data1 = 4'(nin); in_mode1 = 1'b0;
      out_ready1 = !(c >= 3 && c < 8);
      #1;
      if (c == 7) begin
        checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready1); end
        checks++; if (nin - nout != 2) begin errors++; $display("FAIL stall_held: got %0d expected 2", nin - nout); end
      end
      if (out_valid1 && !out_ready1) begin
        if (!have_held) begin
          held = out_data1; have_held = 1;
        end else begin
          checks++;
          if (out_data1 !== held) begin errors++; $display("FAIL stall_stable: got %0d expected %0d", out_data1, held); end
        end
      end else if (out_valid1 && out_ready1) begin
        have_held = 0;
        checks++;
        if (out_data1 !== st_exp[nout]) begin errors++; $display("FAIL stall_data[%0d]: got %0d expected %0d", nout, out_data1, st_exp[nout]); end
        nout++;
      end
      if (in_valid1 && in_ready1) nin++;
      step();
    end
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    checks++; if (nout != 8 || nin != 8) begin errors++; $display("FAIL stall_count: got %0d out %0d in expected 8", nout, nin); end
  endtask

  // One isolated beat through the 4-lane unit; optionally clear in the output handshake cycle
  task automatic beat4(input logic [15:0] d, input bit clr, input logic [15:0] exp, input int exp_cnt, input string name);
    bit got = 0;
    in_valid4 = 1'b1; in_data4 = d; in_mode4 = 1'b0; out_ready4 = 1'b1;
    for (int n = 0; n < 10 && !in_ready4; n++) step();
    step();
    in_valid4 = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid4) begin got = 1; break; end
      step();
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s_timeout: got no out_valid expected out_valid within 10 cycles", name);
    end else if (out_data4 !== exp) begin
      errors++; $display("FAIL %s_data: got %h expected %h", name, out_data4, exp);
    end
    sat_clr4 = clr;
    step();
    sat_clr4 = 1'b0;
    checks++;
    if (sat_count4 !== 3'(exp_cnt)) begin errors++; $display("FAIL %s_sat_count: got %0d expected %0d", name, sat_count4, exp_cnt); end
  endtask

  task automatic test_lanes_sat();
    beat4(16'hF820, 0, 16'hFF80, 2, "lanes_b1");
    beat4(16'hF820, 0, 16'hFF80, 4, "lanes_b2");
    beat4(16'hF820, 0, 16'hFF80, 6, "lanes_b3");
    beat4(16'hF820, 0, 16'hFF80, 7, "lanes_ceiling");
    beat4(16'hF820, 1, 16'hFF80, 0, "lanes_clr");
    beat4(16'h8321, 0, 16'hFA84, 1, "lanes_after_clr");
  endtask

  task automatic test_reset_midstream();
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_mode1 = 1'b0; in_data1 = 4'd8;
    step();
    in_data1 = 4'd15;
    step();
    in_valid1 = 1'b0;
    checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL midrst_inflight: got %b expected 1", out_valid1); end
    reset = 1'b1;
    step();
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid1); end
    checks++; if (sat_count1 !== 16'd0) begin errors++; $display("FAIL midrst_sat_count: got %0d expected 0", sat_count1); end
    checks++; if (out_data1 !== 4'd0) begin errors++; $display("FAIL midrst_out_data: got %0d expected 0", out_data1); end
    reset = 1'b0; out_ready1 = 1'b1; exp_cnt1 = 0;
    #1;
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready1); end
    for (int n = 0; n < 6; n++) begin
      step();
      checks++;
      if (out_valid1 !== 1'b0) begin errors++; $display("FAIL midrst_stale[%0d]: got out_valid %b expected 0", n, out_valid1); end
    end
    beat1(4'd2, 1'b0, 4'd8, 0, "midrst_after");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; in_mode1 = 1'b0; out_ready1 = 1'b1; sat_clr1 = 1'b0;
    in_valid4 = 1'b0; in_data4 = '0; in_mode4 = 1'b0; out_ready4 = 1'b1; sat_clr4 = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    test_reset();
    test_exact();
    test_approx();
    test_back_to_back();
    test_stall();
    test_lanes_sat();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
